bike_motion_ctrl: RTL and testbench

- Per-player bike state machine that sits directly upstream of the sprite address converter.
- Tracks the bike's 30x30 sprite top-left position on the 640x480 frame and its heading. Handles turn requests, stepped motion on frame ticks, wall and trail collisions, and the crash sequence.
- Drives the converter's startaddr (top-left pixel address, row*640+col) and orient (0..3 heading, 5 crash sprite).

---
 rtl/bike_motion_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_bike_motion_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bike_motion_ctrl.sv
// Bike position/heading controller for one player: turn latching, stepped motion,
// wall/trail crash handling and the crash-hold sequence feeding the sprite converter.
module bike_motion_ctrl #(
  parameter int START_X         = 100,
  parameter int START_Y         = 225,
  parameter int START_DIR       = 1,
  parameter int STEP            = 2,
  parameter int FRAMES_PER_MOVE = 1,
  parameter int CRASH_HOLD      = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        turn_left,
  input  logic        turn_right,
  input  logic        collide,
  output logic [18:0] startaddr,
  output logic [2:0]  orient,
  output logic [9:0]  pos_x,
  output logic [8:0]  pos_y,
  output logic        alive,
  output logic        crashed
);

  localparam int MCW   = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
  localparam int CCW   = (CRASH_HOLD > 1) ? $clog2(CRASH_HOLD + 1) : 1;
  localparam int MAX_X = 640 - 30;
  localparam int MAX_Y = 480 - 30;

  localparam logic [9:0]  RST_X    = 10'(START_X);
  localparam logic [8:0]  RST_Y    = 9'(START_Y);
  localparam logic [1:0]  RST_DIR  = 2'(START_DIR);
  localparam logic [18:0] RST_ADDR = 19'(START_Y * 640 + START_X);
  localparam logic [2:0]  CRASH_SPRITE = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [9:0]  pos_x_reg, pos_x_next;
  logic [8:0]  pos_y_reg, pos_y_next;
  logic [1:0]  dir_reg, dir_next;
  logic [2:0]  orient_reg, orient_next;
  logic [18:0] startaddr_reg, startaddr_next;
  logic [MCW-1:0] move_cnt_reg, move_cnt_next;
  logic [CCW-1:0] crash_cnt_reg, crash_cnt_next;
  logic        pend_valid_reg, pend_valid_next;
  logic        pend_right_reg, pend_right_next;

  logic              move_event;
  logic              turn_pulse;
  logic              eff_valid;
  logic              eff_right;
  logic [1:0]        dir_turned;
  logic signed [11:0] cand_x;
  logic signed [10:0] cand_y;
  logic              cand_ok;

  // A turn pulse in the same cycle as the move event counts as "before" the move.
  always_comb begin
    move_event = frame_tick && (move_cnt_reg == MCW'(FRAMES_PER_MOVE - 1));
    turn_pulse = turn_left ^ turn_right;
    eff_valid  = turn_pulse | pend_valid_reg;
    eff_right  = turn_pulse ? turn_right : pend_right_reg;
    dir_turned = dir_reg;
    if (eff_valid) begin
      dir_turned = eff_right ? (dir_reg + 2'd1) : (dir_reg + 2'd3);
    end
    cand_x = $signed({2'b00, pos_x_reg});
    cand_y = $signed({2'b00, pos_y_reg});
    case (dir_turned)
      2'd0:    cand_y = $signed({2'b00, pos_y_reg}) - $signed(11'(STEP));
      2'd1:    cand_x = $signed({2'b00, pos_x_reg}) + $signed(12'(STEP));
      2'd2:    cand_y = $signed({2'b00, pos_y_reg}) + $signed(11'(STEP));
      default: cand_x = $signed({2'b00, pos_x_reg}) - $signed(12'(STEP));
    endcase
    cand_ok = !cand_x[11] && (cand_x <= $signed(12'(MAX_X))) &&
              !cand_y[10] && (cand_y <= $signed(11'(MAX_Y)));
  end

  always_comb begin
    state_next      = state_reg;
    pos_x_next      = pos_x_reg;
    pos_y_next      = pos_y_reg;
    dir_next        = dir_reg;
    move_cnt_next   = move_cnt_reg;
    crash_cnt_next  = crash_cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_right_next = pend_right_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next      = RUN;
          move_cnt_next   = '0;
          pend_valid_next = 1'b0;
          pend_right_next = 1'b0;
        end
      end
      RUN: begin
        if (turn_pulse) begin
          pend_valid_next = 1'b1;
          pend_right_next = turn_right;
        end
        if (collide) begin
          state_next      = CRASH;
          crash_cnt_next  = '0;
          pend_valid_next = 1'b0;
          pend_right_next = 1'b0;
        end else if (move_event) begin
          move_cnt_next   = '0;
          pend_valid_next = 1'b0;
          pend_right_next = 1'b0;
          if (cand_ok) begin
            pos_x_next = cand_x[9:0];
            pos_y_next = cand_y[8:0];
            dir_next   = dir_turned;
          end else begin
            state_next     = CRASH;
            crash_cnt_next = '0;
          end
        end else if (frame_tick) begin
          move_cnt_next = move_cnt_reg + MCW'(1);
        end
      end
      CRASH: begin
        if (frame_tick) begin
          if (int'(crash_cnt_reg) + 1 >= CRASH_HOLD) begin
            state_next = DONE;
          end else begin
            crash_cnt_next = crash_cnt_reg + CCW'(1);
          end
        end
      end
      default: begin
        if (start) begin
          state_next      = IDLE;
          pos_x_next      = RST_X;
          pos_y_next      = RST_Y;
          dir_next        = RST_DIR;
          move_cnt_next   = '0;
          crash_cnt_next  = '0;
          pend_valid_next = 1'b0;
          pend_right_next = 1'b0;
        end
      end
    endcase

    orient_next = ((state_next == CRASH) || (state_next == DONE)) ? CRASH_SPRITE
                                                                  : {1'b0, dir_next};
    startaddr_next = 19'(pos_y_next) * 19'd640 + 19'(pos_x_next);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      pos_x_reg      <= RST_X;
      pos_y_reg      <= RST_Y;
      dir_reg        <= RST_DIR;
      orient_reg     <= {1'b0, RST_DIR};
      startaddr_reg  <= RST_ADDR;
      move_cnt_reg   <= '0;
      crash_cnt_reg  <= '0;
      pend_valid_reg <= 1'b0;
      pend_right_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pos_x_reg      <= pos_x_next;
      pos_y_reg      <= pos_y_next;
      dir_reg        <= dir_next;
      orient_reg     <= orient_next;
      startaddr_reg  <= startaddr_next;
      move_cnt_reg   <= move_cnt_next;
      crash_cnt_reg  <= crash_cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_right_reg <= pend_right_next;
    end
  end

  assign startaddr = startaddr_reg;
  assign orient    = orient_reg;
  assign pos_x     = pos_x_reg;
  assign pos_y     = pos_y_reg;
  assign alive     = (state_reg == RUN);
  assign crashed   = (state_reg == DONE);

endmodule

// File: tb/tb_bike_motion_ctrl.sv
// Scoreboard bench for bike_motion_ctrl: a default instance and a near-right-wall instance.
module tb_bike_motion_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic ft_a = 0, st_a = 0, tl_a = 0, tr_a = 0, co_a = 0;
  logic ft_b = 0, st_b = 0, tl_b = 0, tr_b = 0, co_b = 0;
  logic [18:0] addr_a, addr_b;
  logic [2:0]  or_a, or_b;
  logic [9:0]  x_a, x_b;
  logic [8:0]  y_a, y_b;
  logic        al_a, al_b, cr_a, cr_b;

  bike_motion_ctrl dut_a (
    .clock(clock), .reset(reset), .frame_tick(ft_a), .start(st_a),
    .turn_left(tl_a), .turn_right(tr_a), .collide(co_a),
    .startaddr(addr_a), .orient(or_a), .pos_x(x_a), .pos_y(y_a),
    .alive(al_a), .crashed(cr_a)
  );

  bike_motion_ctrl #(.START_X(606), .CRASH_HOLD(3)) dut_b (
    .clock(clock), .reset(reset), .frame_tick(ft_b), .start(st_b),
    .turn_left(tl_b), .turn_right(tr_b), .collide(co_b),
    .startaddr(addr_b), .orient(or_b), .pos_x(x_b), .pos_y(y_b),
    .alive(al_b), .crashed(cr_b)
  );

  typedef struct {
    int          dut;
    string       name;
    logic [18:0] addr;
    logic [2:0]  orient;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        alive;
    logic        crashed;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Monitor: drains every expectation queued since the last falling edge.
  initial begin
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [18:0] a;
        logic [2:0]  o;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        al, cr;
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          a = addr_a; o = or_a; x = x_a; y = y_a; al = al_a; cr = cr_a;
        end else begin
          a = addr_b; o = or_b; x = x_b; y = y_b; al = al_b; cr = cr_b;
        end
        total++;
        if (a !== e.addr || o !== e.orient || x !== e.x || y !== e.y ||
            al !== e.alive || cr !== e.crashed) begin
          bad++;
          $display("FAIL %s: got addr=%0d orient=%0d x=%0d y=%0d alive=%0b crashed=%0b, want addr=%0d orient=%0d x=%0d y=%0d alive=%0b crashed=%0b",
                   e.name, a, o, x, y, al, cr, e.addr, e.orient, e.x, e.y, e.alive, e.crashed);
        end else begin
          $display("ok   %s: addr=%0d orient=%0d x=%0d y=%0d alive=%0b crashed=%0b",
                   e.name, a, o, x, y, al, cr);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_state(input int dut, input string name, input int addr, input int o,
                              input int x, input int y, input logic al, input logic cr);
    exp_t e;
    e.dut = dut; e.name = name; e.addr = 19'(addr); e.orient = 3'(o);
    e.x = 10'(x); e.y = 9'(y); e.alive = al; e.crashed = cr;
    exp_q.push_back(e);
  endtask

  task automatic tick_a();
    ft_a = 1; cyc(); ft_a = 0; cyc(); cyc();
  endtask

  task automatic tick_b();
    ft_b = 1; cyc(); ft_b = 0; cyc(); cyc();
  endtask

  task automatic start_a();
    st_a = 1; cyc(); st_a = 0; cyc();
  endtask

  initial begin
    // ---- instance A: default parameters ----
    reset = 1; cyc(); cyc(); cyc();
    expect_state(0, "reset_hold", 144100, 1, 100, 225, 0, 0);
    reset = 0; cyc();
    for (int i = 0; i < 5; i++) tick_a();
    expect_state(0, "idle_ignores_ticks", 144100, 1, 100, 225, 0, 0);

    start_a();
    expect_state(0, "run_entered", 144100, 1, 100, 225, 1, 0);
    for (int i = 0; i < 5; i++) tick_a();
    expect_state(0, "five_moves_right", 144110, 1, 110, 225, 1, 0);

    tl_a = 1; cyc(); tl_a = 0; cyc();
    expect_state(0, "turn_pending_no_move", 144110, 1, 110, 225, 1, 0);
    tick_a();
    expect_state(0, "turn_left_up", 142830, 0, 110, 223, 1, 0);

    tl_a = 1; tr_a = 1; cyc(); tl_a = 0; tr_a = 0; cyc();
    tick_a();
    expect_state(0, "both_turns_ignored", 141550, 0, 110, 221, 1, 0);

    tl_a = 1; cyc(); tl_a = 0; cyc(); tr_a = 1; cyc(); tr_a = 0; cyc();
    tick_a();
    expect_state(0, "last_turn_wins", 141552, 1, 112, 221, 1, 0);

    tl_a = 1; cyc(); tl_a = 0; cyc();
    co_a = 1; ft_a = 1; cyc(); co_a = 0; ft_a = 0;
    expect_state(0, "collide_beats_move", 141552, 5, 112, 221, 0, 0);
    cyc();
    st_a = 1; tl_a = 1; cyc(); st_a = 0; tl_a = 0; cyc();
    expect_state(0, "crash_ignores_inputs", 141552, 5, 112, 221, 0, 0);

    for (int i = 0; i < 119; i++) tick_a();
    expect_state(0, "crash_hold_minus1", 141552, 5, 112, 221, 0, 0);
    tick_a();
    expect_state(0, "done_after_hold", 141552, 5, 112, 221, 0, 1);

    st_a = 1; cyc(); st_a = 0;
    expect_state(0, "done_start_to_idle", 144100, 1, 100, 225, 0, 0);
    cyc();

    // reset during CRASH
    start_a();
    co_a = 1; cyc(); co_a = 0; cyc();
    tick_a(); tick_a();
    reset = 1; cyc();
    expect_state(0, "reset_in_crash", 144100, 1, 100, 225, 0, 0);
    reset = 0; cyc();
    start_a(); tick_a();
    expect_state(0, "resume_after_crash_reset", 144102, 1, 102, 225, 1, 0);

    // reset coincident with a move event
    tick_a();
    expect_state(0, "second_move", 144104, 1, 104, 225, 1, 0);
    tl_a = 1; cyc(); tl_a = 0;
    ft_a = 1; reset = 1; cyc(); ft_a = 0;
    expect_state(0, "reset_mid_move", 144100, 1, 100, 225, 0, 0);
    reset = 0; cyc();
    start_a(); tick_a();
    expect_state(0, "resume_after_run_reset", 144102, 1, 102, 225, 1, 0);

    // ---- instance B: START_X=606, CRASH_HOLD=3 ----
    reset = 1; cyc(); reset = 0; cyc();
    expect_state(1, "b_reset", 144606, 1, 606, 225, 0, 0);
    st_b = 1; cyc(); st_b = 0; cyc();
    tick_b();
    expect_state(1, "b_x608", 144608, 1, 608, 225, 1, 0);
    tick_b();
    expect_state(1, "b_x610_edge", 144610, 1, 610, 225, 1, 0);
    tick_b();
    expect_state(1, "b_wall_crash", 144610, 5, 610, 225, 0, 0);
    tick_b(); tick_b();
    expect_state(1, "b_hold_not_done", 144610, 5, 610, 225, 0, 0);
    tick_b();
    expect_state(1, "b_done", 144610, 5, 610, 225, 0, 1);

    cyc(); cyc();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, want finish");
    $fatal(1, "timeout");
  end

endmodule
